// File: rtl/comp_pkg.sv
// ============================================================================
//  Module      : comp_pkg
//  Description : Shared relation type and one-hot decode for the comparator.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package comp_pkg;

    typedef enum logic [1:0] {
        REL_NONE = 2'd0,
        REL_LT   = 2'd1,
        REL_EQ   = 2'd2,
        REL_GT   = 2'd3
    } rel_t;

    // Returns {gt, eq, lt}; NONE decodes to all zeros.
    function automatic logic [2:0] rel_decode(input rel_t rel);
        logic [2:0] flags;
        case (rel)
            REL_GT:  flags = 3'b100;
            REL_EQ:  flags = 3'b010;
            REL_LT:  flags = 3'b001;
            default: flags = 3'b000;
        endcase
        return flags;
    endfunction

endpackage

`default_nettype wire

// File: rtl/comp_core.sv
// ============================================================================
//  Module      : comp_core
//  Description : Combinational WIDTH-bit magnitude compare, signed or unsigned.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module comp_core
    import comp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output rel_t             rel
);

    generate
        if (SIGNED) begin : g_signed
            always_comb begin
                if ($signed(a) < $signed(b)) begin
                    rel = REL_LT;
                end else if (a == b) begin
                    rel = REL_EQ;
                end else begin
                    rel = REL_GT;
                end
            end
        end else begin : g_unsigned
            always_comb begin
                if (a < b) begin
                    rel = REL_LT;
                end else if (a == b) begin
                    rel = REL_EQ;
                end else begin
                    rel = REL_GT;
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/comp_debounce.sv
// ============================================================================
//  Module      : comp_debounce
//  Description : Registered comparator whose reported relation only changes
//                after DEBOUNCE consecutive agreeing valid samples.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module comp_debounce
    import comp_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SIGNED   = 1'b0,
    parameter int DEBOUNCE = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clear,
    output logic             known,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_ls_b,
    output logic             changed
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    localparam logic [0:0] ST_UNKNOWN = 1'b0;
    localparam logic [0:0] ST_STABLE  = 1'b1;

    rel_t             w_rel;

    logic             r_raw_vld;
    rel_t             r_raw_rel;

    logic [0:0]       r_state;
    rel_t             r_rep_rel;
    rel_t             r_cand_rel;
    logic [CNT_W-1:0] r_cnt;

    logic [0:0]       w_state_nxt;
    rel_t             w_rep_nxt;
    rel_t             w_cand_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_post;
    logic             w_changed_nxt;

    logic             w_known_nxt;
    logic [2:0]       w_flags_nxt;

    logic             r_known;
    logic             r_gt;
    logic             r_eq;
    logic             r_ls;
    logic             r_changed;

    comp_core #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_core (
        .a   (a),
        .b   (b),
        .rel (w_rel)
    );

    // Stage 1: raw relation capture; clear discards the sample of the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw_vld <= 1'b0;
            r_raw_rel <= REL_NONE;
        end else begin
            r_raw_vld <= in_valid & ~clear;
            if (in_valid && !clear) begin
                r_raw_rel <= w_rel;
            end
        end
    end

    // Stage 2 state register, including the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_UNKNOWN;
            r_rep_rel  <= REL_NONE;
            r_cand_rel <= REL_NONE;
            r_cnt      <= '0;
            r_known    <= 1'b0;
            r_gt       <= 1'b0;
            r_eq       <= 1'b0;
            r_ls       <= 1'b0;
            r_changed  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rep_rel  <= w_rep_nxt;
            r_cand_rel <= w_cand_nxt;
            r_cnt      <= w_cnt_nxt;
            r_known    <= w_known_nxt;
            r_gt       <= w_flags_nxt[2];
            r_eq       <= w_flags_nxt[1];
            r_ls       <= w_flags_nxt[0];
            r_changed  <= w_changed_nxt;
        end
    end

    // Next-state: run counting toward DEBOUNCE; invalid cycles leave the run intact.
    always_comb begin
        w_state_nxt   = r_state;
        w_rep_nxt     = r_rep_rel;
        w_cand_nxt    = r_cand_rel;
        w_cnt_nxt     = r_cnt;
        w_changed_nxt = 1'b0;
        w_cnt_post    = (r_raw_rel == r_cand_rel) ? (r_cnt + CNT_W'(1)) : CNT_W'(1);

        if (clear) begin
            w_state_nxt = ST_UNKNOWN;
            w_rep_nxt   = REL_NONE;
            w_cand_nxt  = REL_NONE;
            w_cnt_nxt   = '0;
        end else if (r_raw_vld) begin
            if (r_raw_rel == r_rep_rel) begin
                w_cand_nxt = REL_NONE;
                w_cnt_nxt  = '0;
            end else if (w_cnt_post == CNT_W'(DEBOUNCE)) begin
                w_state_nxt   = ST_STABLE;
                w_rep_nxt     = r_raw_rel;
                w_cand_nxt    = REL_NONE;
                w_cnt_nxt     = '0;
                w_changed_nxt = 1'b1;
            end else begin
                w_cand_nxt = r_raw_rel;
                w_cnt_nxt  = w_cnt_post;
            end
        end
    end

    // Output decode of the next state, registered alongside it.
    always_comb begin
        w_known_nxt = (w_state_nxt == ST_STABLE);
        w_flags_nxt = rel_decode(w_rep_nxt);
    end

    assign known   = r_known;
    assign a_gt_b  = r_gt;
    assign a_eq_b  = r_eq;
    assign a_ls_b  = r_ls;
    assign changed = r_changed;

endmodule

`default_nettype wire
